bp_gshare_predictor: RTL and testbench
======================================

Name: bp_gshare_predictor

Overview:
- Next-generation branch direction predictor: table of 2^INDEX_BITS saturating counters, each CTR_WIDTH bits wide, replacing the single fixed 2-bit counter.
- Registered prediction port for fetch; separate update port for resolved branches from execute/retire.
- Optional global-history XOR indexing (gshare); bimodal (PC-indexed) otherwise.
- Built-in saturating mispredict counter for performance monitoring.

Parameters:
- PC_WIDTH, 32, width of branch PC.
- INDEX_BITS, 6, log2 of table entries; index taken from PC[INDEX_BITS+1:2].
- CTR_WIDTH, 2, counter width; legal 1..4.
- HIST_BITS, 6, global history length; legal 1..INDEX_BITS; used only with the gshare option.
- MISS_CNT_WIDTH, 16, mispredict counter width.

Ports:
- i_clock  input  1  sole clock; all state updates on rising edge.
- i_init_n  input  1  reset, synchronous, active-low.
- i_pred_valid  input  1  prediction request this cycle.
- i_pred_pc  input  PC_WIDTH  PC of branch to predict.
- o_pred_valid  output  1  prediction result valid; one cycle after request.
- o_pred_taken  output  1  predicted direction (1 = taken).
- o_pred_index  output  INDEX_BITS  table index used; carried with branch and returned on update.
- o_pred_ctr  output  CTR_WIDTH  raw counter value read.
- i_upd_valid  input  1  resolved-branch update this cycle.
- i_upd_index  input  INDEX_BITS  index from the original prediction.
- i_upd_taken  input  1  actual outcome.
- i_upd_pred_taken  input  1  direction originally predicted.
- o_history  output  HIST_BITS  current global history; all-zero when gshare disabled.
- o_miss_count  output  MISS_CNT_WIDTH  saturating mispredict count.

Behaviour:
- Reset (i_init_n = 0 at clock edge):
  - every counter = 2^(CTR_WIDTH-1), i.e. weakly taken;
  - history = 0; o_miss_count = 0; o_pred_valid = 0; o_pred_taken = 0; o_pred_index = 0; o_pred_ctr = 0.
  - Reset overrides any concurrent predict or update; in-flight request is dropped.
- Direction: counter MSB = 1 means taken.
- Prediction:
  - index computed combinationally from i_pred_pc (and history) in cycle N;
  - counter value, index and MSB are registered and presented at N+1 with o_pred_valid = 1;
  - o_pred_valid = 0 in any cycle after i_pred_valid = 0; other outputs hold their last values.
- Update in cycle N (i_upd_valid = 1):
  - at the edge, counter[i_upd_index] increments if taken, saturating at 2^CTR_WIDTH-1;
  - it decrements if not taken, saturating at 0.
  - No wrap-around in either direction.
- Simultaneous predict and update to the same index in cycle N:
  - the prediction returns the pre-update counter value (no forwarding);
  - the update is applied normally.
- Multiple cycles: one predict and one update accepted per cycle, with no stall or backpressure.
- Mispredict counter:
  - increments when i_upd_valid and i_upd_taken != i_upd_pred_taken;
  - saturates at all-ones, never wraps;
  - cleared only by reset.
- History (gshare only):
  - on i_upd_valid, history <= {history[HIST_BITS-2:0], i_upd_taken};
  - a prediction in the same cycle uses the old history.
- Index arithmetic (gshare): pc_idx XOR zero-extended history, truncated to INDEX_BITS.

Optional Feature:
- Macro BP_GSHARE_HIST_EN.
- Defined: history register present; index = PC[INDEX_BITS+1:2] XOR history; o_history reflects the register.
- Undefined: pure bimodal; index = PC[INDEX_BITS+1:2]; no history flops; o_history tied to 0.
- Update and mispredict behaviour are identical in both builds.

Decomposition:
- Package bp_pkg:
  - counter-direction constants (TAKEN/NOT_TAKEN);
  - function for the saturating next-counter value;
  - function for the weakly-taken reset value given width.
- One sub-module, bp_counter_table:
  - holds the counter array with synchronous reset, one read port and one saturating-update write port;
  - top level holds the index logic, history, output registers and mispredict counter.

Test Plan:
- Reset, then predict PC 0x40 -> next cycle o_pred_valid = 1, o_pred_taken = 1, o_pred_ctr = 2 (CTR_WIDTH = 2), o_pred_index = 16 (bimodal).
- Three not-taken updates to index 16, then predict 0x40 -> o_pred_ctr = 0, o_pred_taken = 0; a fourth not-taken update leaves the counter at 0.
- Five taken updates to index 5, CTR_WIDTH = 3 -> counter saturates at 7; predict shows o_pred_ctr = 7 and the counter does not wrap.
- Same-cycle predict and taken-update on index 16 with counter = 1 -> o_pred_ctr = 1 next cycle; repeat predict shows 2.
- 70000 mispredicting updates with MISS_CNT_WIDTH = 16 -> o_miss_count stops at 0xFFFF; a correctly predicted update does not increment it; mid-run reset returns it to 0.
- BP_GSHARE_HIST_EN: updates taken, taken, not-taken -> o_history = 6'b000110; predict PC 0x40 -> o_pred_index = 16 ^ 6 = 22.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and counter helpers for the branch direction predictor.
// Counters are handled at the widest legal width and truncated by the user.
package bp_pkg;

    localparam logic TAKEN         = 1'b1;
    localparam logic NOT_TAKEN     = 1'b0;
    localparam int   CTR_MAX_WIDTH = 4;

    typedef logic [CTR_MAX_WIDTH-1:0] ctr_t;

    // Weakly-taken value: only the MSB of a width-bit counter set.
    function automatic ctr_t ctr_reset_value(input int width);
        ctr_t value;
        value = ctr_t'(1) << (width - 1);
        return value;
    endfunction

    // Saturating step toward the resolved direction; never wraps.
    function automatic ctr_t ctr_saturate(input ctr_t ctr, input logic taken, input int width);
        ctr_t limit;
        ctr_t result;
        limit  = ctr_t'((1 << width) - 1);
        result = ctr;
        if (taken == TAKEN) begin
            if (ctr != limit) begin
                result = ctr + ctr_t'(1);
            end
        end else begin
            if (ctr != '0) begin
                result = ctr - ctr_t'(1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of saturating direction counters: one combinational read port and one
// saturating-update write port; every entry reloads weakly-taken on reset.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CTR_WIDTH  = 2
) (
    input  logic                  i_clock,
    input  logic                  i_init_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [CTR_WIDTH-1:0]  rd_ctr,
    input  logic                  wr_valid,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(ctr_reset_value(CTR_WIDTH));

    logic [ENTRIES-1:0][CTR_WIDTH-1:0] ctr_vals;
    logic [ENTRIES-1:0]                wr_sel;
    logic [CTR_WIDTH-1:0]              wr_ctr_next;

    // Read sees the pre-update value, so a same-cycle update is not forwarded.
    assign rd_ctr      = ctr_vals[rd_index];
    assign wr_ctr_next = CTR_WIDTH'(ctr_saturate(ctr_t'(ctr_vals[wr_index]), wr_taken, CTR_WIDTH));

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [CTR_WIDTH-1:0] ctr_reg;

            assign wr_sel[gi]   = wr_valid && (wr_index == INDEX_BITS'(gi));
            assign ctr_vals[gi] = ctr_reg;

            always_ff @(posedge i_clock) begin
                if (!i_init_n) begin
                    ctr_reg <= CTR_RESET;
                end else if (wr_sel[gi]) begin
                    ctr_reg <= wr_ctr_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/bp_gshare_predictor.sv
// Branch direction predictor: registered prediction port, resolved-branch update
// port, saturating mispredict counter. Define BP_GSHARE_HIST_EN for gshare indexing.
module bp_gshare_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH       = 32,
    parameter int INDEX_BITS     = 6,
    parameter int CTR_WIDTH      = 2,
    parameter int HIST_BITS      = 6,
    parameter int MISS_CNT_WIDTH = 16
) (
    input  logic                      i_clock,
    input  logic                      i_init_n,
    input  logic                      i_pred_valid,
    input  logic [PC_WIDTH-1:0]       i_pred_pc,
    output logic                      o_pred_valid,
    output logic                      o_pred_taken,
    output logic [INDEX_BITS-1:0]     o_pred_index,
    output logic [CTR_WIDTH-1:0]      o_pred_ctr,
    input  logic                      i_upd_valid,
    input  logic [INDEX_BITS-1:0]     i_upd_index,
    input  logic                      i_upd_taken,
    input  logic                      i_upd_pred_taken,
    output logic [HIST_BITS-1:0]      o_history,
    output logic [MISS_CNT_WIDTH-1:0] o_miss_count
);

    logic [INDEX_BITS-1:0]     pc_index;
    logic [INDEX_BITS-1:0]     pred_index;
    logic [CTR_WIDTH-1:0]      rd_ctr;
    logic                      mispredict;
    logic                      unused_pc_bits;

    logic                      pred_valid_reg;
    logic                      pred_taken_reg;
    logic [INDEX_BITS-1:0]     pred_index_reg;
    logic [CTR_WIDTH-1:0]      pred_ctr_reg;
    logic [MISS_CNT_WIDTH-1:0] miss_count_reg;

    // Instructions are word aligned, so the two low PC bits carry no information.
    assign pc_index       = i_pred_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{i_pred_pc[PC_WIDTH-1:INDEX_BITS+2], i_pred_pc[1:0]};

`ifdef BP_GSHARE_HIST_EN
    logic [HIST_BITS-1:0] history_reg;
    logic [HIST_BITS-1:0] history_next;

    generate
        if (HIST_BITS == 1) begin : g_hist_single
            assign history_next = i_upd_taken;
        end else begin : g_hist_shift
            assign history_next = {history_reg[HIST_BITS-2:0], i_upd_taken};
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (!i_init_n) begin
            history_reg <= '0;
        end else if (i_upd_valid) begin
            history_reg <= history_next;
        end
    end

    // A prediction issued alongside an update still hashes with the old history.
    assign pred_index = pc_index ^ INDEX_BITS'(history_reg);
    assign o_history  = history_reg;
`else
    assign pred_index = pc_index;
    assign o_history  = '0;
`endif

    bp_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_WIDTH  (CTR_WIDTH)
    ) u_table (
        .i_clock  (i_clock),
        .i_init_n (i_init_n),
        .rd_index (pred_index),
        .rd_ctr   (rd_ctr),
        .wr_valid (i_upd_valid),
        .wr_index (i_upd_index),
        .wr_taken (i_upd_taken)
    );

    // Result fields hold their last values when no request is made.
    always_ff @(posedge i_clock) begin
        if (!i_init_n) begin
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= NOT_TAKEN;
            pred_index_reg <= '0;
            pred_ctr_reg   <= '0;
        end else begin
            pred_valid_reg <= i_pred_valid;
            if (i_pred_valid) begin
                pred_taken_reg <= rd_ctr[CTR_WIDTH-1];
                pred_index_reg <= pred_index;
                pred_ctr_reg   <= rd_ctr;
            end
        end
    end

    assign mispredict = i_upd_valid && (i_upd_taken != i_upd_pred_taken);

    always_ff @(posedge i_clock) begin
        if (!i_init_n) begin
            miss_count_reg <= '0;
        end else if (mispredict && (miss_count_reg != '1)) begin
            miss_count_reg <= miss_count_reg + MISS_CNT_WIDTH'(1);
        end
    end

    assign o_pred_valid = pred_valid_reg;
    assign o_pred_taken = pred_taken_reg;
    assign o_pred_index = pred_index_reg;
    assign o_pred_ctr   = pred_ctr_reg;
    assign o_miss_count = miss_count_reg;

endmodule

// File: tb/tb_bp_gshare_predictor.sv
// Bench for bp_gshare_predictor: two instances (2-bit and 3-bit counters) share
// stimulus and are checked against an arithmetic reference model.
module tb_bp_gshare_predictor;

    localparam int ENTRIES   = 64;
    localparam int HIST_BITS = 6;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        init_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [5:0]  upd_index;
    logic        upd_taken;
    logic        upd_pred_taken;

    logic        o2_pred_valid, o2_pred_taken;
    logic [5:0]  o2_pred_index;
    logic [1:0]  o2_pred_ctr;
    logic [5:0]  o2_history;
    logic [15:0] o2_miss_count;

    logic        o3_pred_valid, o3_pred_taken;
    logic [5:0]  o3_pred_index;
    logic [2:0]  o3_pred_ctr;
    logic [5:0]  o3_history;
    logic [15:0] o3_miss_count;

    bp_gshare_predictor dut (
        .i_clock          (clk),
        .i_init_n         (init_n),
        .i_pred_valid     (pred_valid),
        .i_pred_pc        (pred_pc),
        .o_pred_valid     (o2_pred_valid),
        .o_pred_taken     (o2_pred_taken),
        .o_pred_index     (o2_pred_index),
        .o_pred_ctr       (o2_pred_ctr),
        .i_upd_valid      (upd_valid),
        .i_upd_index      (upd_index),
        .i_upd_taken      (upd_taken),
        .i_upd_pred_taken (upd_pred_taken),
        .o_history        (o2_history),
        .o_miss_count     (o2_miss_count)
    );

    bp_gshare_predictor #(.CTR_WIDTH(3)) dut3 (
        .i_clock          (clk),
        .i_init_n         (init_n),
        .i_pred_valid     (pred_valid),
        .i_pred_pc        (pred_pc),
        .o_pred_valid     (o3_pred_valid),
        .o_pred_taken     (o3_pred_taken),
        .o_pred_index     (o3_pred_index),
        .o_pred_ctr       (o3_pred_ctr),
        .i_upd_valid      (upd_valid),
        .i_upd_index      (upd_index),
        .i_upd_taken      (upd_taken),
        .i_upd_pred_taken (upd_pred_taken),
        .o_history        (o3_history),
        .o_miss_count     (o3_miss_count)
    );

    // Reference model state.
    int m_ctr2 [ENTRIES];
    int m_ctr3 [ENTRIES];
    int m_hist;
    int m_miss;
    int e_valid, e_taken2, e_taken3, e_index, e_ctr2, e_ctr3;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_ctr2[i] = 2;
            m_ctr3[i] = 4;
        end
        m_hist = 0; m_miss = 0;
        e_valid = 0; e_taken2 = 0; e_taken3 = 0; e_index = 0; e_ctr2 = 0; e_ctr3 = 0;
    endfunction

    function automatic int model_index(input logic [31:0] pc);
        int idx;
        idx = int'(pc >> 2) % ENTRIES;
`ifdef BP_GSHARE_HIST_EN
        idx = idx ^ m_hist;
`endif
        return idx;
    endfunction

    // A PC (with random unused bits) that selects table entry idx right now.
    function automatic logic [31:0] pc_for_index(input int idx);
        int raw;
        logic [31:0] r;
        raw = idx;
`ifdef BP_GSHARE_HIST_EN
        raw = idx ^ m_hist;
`endif
        r = $urandom;
        return (r & 32'hFFFF_FF00) | 32'(raw * 4);
    endfunction

    function automatic void model_step(input bit rst_n, input bit pv, input logic [31:0] pc,
                                       input bit uv, input int uidx, input bit ut, input bit upt);
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_valid = pv ? 1 : 0;
        if (pv) begin
            e_index  = model_index(pc);
            e_ctr2   = m_ctr2[e_index];
            e_ctr3   = m_ctr3[e_index];
            e_taken2 = (e_ctr2 >= 2) ? 1 : 0;
            e_taken3 = (e_ctr3 >= 4) ? 1 : 0;
        end
        if (uv) begin
            if (ut) begin
                m_ctr2[uidx] = (m_ctr2[uidx] < 3) ? m_ctr2[uidx] + 1 : 3;
                m_ctr3[uidx] = (m_ctr3[uidx] < 7) ? m_ctr3[uidx] + 1 : 7;
            end else begin
                m_ctr2[uidx] = (m_ctr2[uidx] > 0) ? m_ctr2[uidx] - 1 : 0;
                m_ctr3[uidx] = (m_ctr3[uidx] > 0) ? m_ctr3[uidx] - 1 : 0;
            end
            if (ut != upt && m_miss < 65535) m_miss++;
`ifdef BP_GSHARE_HIST_EN
            m_hist = ((m_hist * 2) + (ut ? 1 : 0)) % (1 << HIST_BITS);
`endif
        end
    endfunction

    // Applies one cycle of stimulus, advances the model, samples #1 after the edge.
    task automatic drive(input bit rst_n, input bit pv, input logic [31:0] pc, input bit uv,
                         input int uidx, input bit ut, input bit upt, input bit verbose);
        init_n         = rst_n;
        pred_valid     = pv;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_index      = 6'(uidx);
        upd_taken      = ut;
        upd_pred_taken = upt;
        model_step(rst_n, pv, pc, uv, uidx, ut, upt);
        @(posedge clk);
        #1;
        if (verbose)
            $display("[%0t] txn rst_n=%0b pv=%0b pc=%h uv=%0b uidx=%0d ut=%0b upt=%0b -> valid=%0b idx=%0d ctr2=%0d ctr3=%0d hist=%b miss=%0d",
                     $time, rst_n, pv, pc, uv, uidx, ut, upt, o2_pred_valid, o2_pred_index,
                     o2_pred_ctr, o3_pred_ctr, o2_history, o2_miss_count);
    endtask

    task automatic test_reset();
        // Reset with a concurrent predict and mispredicting update: both dropped.
        drive(0, 1, 32'h40, 1, 16, 0, 1, 1);
        drive(0, 1, 32'h40, 1, 16, 0, 1, 1);
        n_checks++; if (o2_pred_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", o2_pred_valid); end
        n_checks++; if (o2_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %0b expected 0", o2_pred_taken); end
        n_checks++; if (o2_pred_index !== 6'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", o2_pred_index); end
        n_checks++; if (o2_pred_ctr !== 2'd0) begin n_fail++; $display("FAIL reset_ctr: got %0d expected 0", o2_pred_ctr); end
        n_checks++; if (o3_pred_ctr !== 3'd0) begin n_fail++; $display("FAIL reset_ctr3: got %0d expected 0", o3_pred_ctr); end
        n_checks++; if (o2_miss_count !== 16'd0) begin n_fail++; $display("FAIL reset_miss: got %0d expected 0", o2_miss_count); end
        n_checks++; if (o2_history !== 6'd0) begin n_fail++; $display("FAIL reset_history: got %b expected 0", o2_history); end
        drive(1, 0, 32'h0, 0, 0, 0, 0, 1);
        n_checks++; if (o2_pred_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %0b expected 0", o2_pred_valid); end
    endtask

    task automatic test_basic_predict();
        drive(1, 1, 32'h40, 0, 0, 0, 0, 1);
        n_checks++; if (o2_pred_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", o2_pred_valid); end
        n_checks++; if (o2_pred_taken !== 1'b1) begin n_fail++; $display("FAIL basic_taken: got %0b expected 1", o2_pred_taken); end
        n_checks++; if (o2_pred_ctr !== 2'd2) begin n_fail++; $display("FAIL basic_ctr: got %0d expected 2", o2_pred_ctr); end
        n_checks++; if (o3_pred_ctr !== 3'd4) begin n_fail++; $display("FAIL basic_ctr3: got %0d expected 4", o3_pred_ctr); end
        n_checks++; if (o2_pred_index !== 6'd16) begin n_fail++; $display("FAIL basic_index: got %0d expected 16", o2_pred_index); end
        drive(1, 0, 32'h0, 0, 0, 0, 0, 1);
        n_checks++; if (o2_pred_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %0b expected 0", o2_pred_valid); end
        n_checks++; if (o2_pred_index !== 6'd16) begin n_fail++; $display("FAIL hold_index: got %0d expected 16", o2_pred_index); end
        n_checks++; if (o2_pred_ctr !== 2'd2) begin n_fail++; $display("FAIL hold_ctr: got %0d expected 2", o2_pred_ctr); end
    endtask

    task automatic test_not_taken_saturation();
        for (int i = 0; i < 3; i++) drive(1, 0, 32'h0, 1, 16, 0, 1, 1);
        drive(1, 1, 32'h40, 0, 0, 0, 0, 1);
        n_checks++; if (o2_pred_ctr !== 2'd0) begin n_fail++; $display("FAIL nt_ctr: got %0d expected 0", o2_pred_ctr); end
        n_checks++; if (o2_pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_taken: got %0b expected 0", o2_pred_taken); end
        n_checks++; if (o3_pred_ctr !== 3'd1) begin n_fail++; $display("FAIL nt_ctr3: got %0d expected 1", o3_pred_ctr); end
        drive(1, 0, 32'h0, 1, 16, 0, 1, 1);
        drive(1, 1, 32'h40, 0, 0, 0, 0, 1);
        n_checks++; if (o2_pred_ctr !== 2'd0) begin n_fail++; $display("FAIL nt_floor: got %0d expected 0", o2_pred_ctr); end
        n_checks++; if (o3_pred_ctr !== 3'd0) begin n_fail++; $display("FAIL nt_floor3: got %0d expected 0", o3_pred_ctr); end
        n_checks++; if (o2_miss_count !== 16'd4) begin n_fail++; $display("FAIL nt_miss: got %0d expected 4", o2_miss_count); end
    endtask

    task automatic test_taken_saturation();
        for (int i = 0; i < 5; i++) drive(1, 0, 32'h0, 1, 5, 1, 1, 1);
        drive(1, 1, pc_for_index(5), 0, 0, 0, 0, 1);
        n_checks++; if (o3_pred_ctr !== 3'd7) begin n_fail++; $display("FAIL t_ctr3: got %0d expected 7", o3_pred_ctr); end
        n_checks++; if (o2_pred_ctr !== 2'd3) begin n_fail++; $display("FAIL t_ctr2: got %0d expected 3", o2_pred_ctr); end
        n_checks++; if (o3_pred_index !== 6'd5) begin n_fail++; $display("FAIL t_index: got %0d expected 5", o3_pred_index); end
        drive(1, 0, 32'h0, 1, 5, 1, 1, 1);
        drive(1, 1, pc_for_index(5), 0, 0, 0, 0, 1);
        n_checks++; if (o3_pred_ctr !== 3'd7) begin n_fail++; $display("FAIL t_nowrap3: got %0d expected 7", o3_pred_ctr); end
        n_checks++; if (o3_pred_taken !== 1'b1) begin n_fail++; $display("FAIL t_taken3: got %0b expected 1", o3_pred_taken); end
        n_checks++; if (o2_miss_count !== 16'd4) begin n_fail++; $display("FAIL t_miss: got %0d expected 4", o2_miss_count); end
    endtask

    task automatic test_back_to_back();
        // Entry 16 sits at 0 in both tables; one taken update brings it to 1.
        drive(1, 0, 32'h0, 1, 16, 1, 1, 1);
        drive(1, 1, pc_for_index(16), 1, 16, 1, 1, 1);
        n_checks++; if (o2_pred_ctr !== 2'd1) begin n_fail++; $display("FAIL same_cycle_ctr: got %0d expected 1", o2_pred_ctr); end
        n_checks++; if (o3_pred_ctr !== 3'd1) begin n_fail++; $display("FAIL same_cycle_ctr3: got %0d expected 1", o3_pred_ctr); end
        drive(1, 1, pc_for_index(16), 0, 0, 0, 0, 1);
        n_checks++; if (o2_pred_ctr !== 2'd2) begin n_fail++; $display("FAIL after_update_ctr: got %0d expected 2", o2_pred_ctr); end
        n_checks++; if (o3_pred_ctr !== 3'd2) begin n_fail++; $display("FAIL after_update_ctr3: got %0d expected 2", o3_pred_ctr); end
        n_checks++; if (o2_pred_index !== 6'd16) begin n_fail++; $display("FAIL after_update_index: got %0d expected 16", o2_pred_index); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit rst_n;
            rst_n = ($urandom_range(0, 63) != 0);
            drive(rst_n, 1'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 63)),
                  1'($urandom), 1'($urandom), 1);
            n_checks++; if (o2_pred_valid !== 1'(e_valid)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b expected %0d", i, o2_pred_valid, e_valid); end
            n_checks++; if (o2_pred_index !== 6'(e_index)) begin n_fail++; $display("FAIL rnd_index[%0d]: got %0d expected %0d", i, o2_pred_index, e_index); end
            n_checks++; if (o2_pred_ctr !== 2'(e_ctr2)) begin n_fail++; $display("FAIL rnd_ctr2[%0d]: got %0d expected %0d", i, o2_pred_ctr, e_ctr2); end
            n_checks++; if (o3_pred_ctr !== 3'(e_ctr3)) begin n_fail++; $display("FAIL rnd_ctr3[%0d]: got %0d expected %0d", i, o3_pred_ctr, e_ctr3); end
            n_checks++; if (o2_pred_taken !== 1'(e_taken2)) begin n_fail++; $display("FAIL rnd_taken2[%0d]: got %0b expected %0d", i, o2_pred_taken, e_taken2); end
            n_checks++; if (o3_pred_taken !== 1'(e_taken3)) begin n_fail++; $display("FAIL rnd_taken3[%0d]: got %0b expected %0d", i, o3_pred_taken, e_taken3); end
            n_checks++; if (o2_history !== 6'(m_hist)) begin n_fail++; $display("FAIL rnd_history[%0d]: got %b expected %0d", i, o2_history, m_hist); end
            n_checks++; if (o3_miss_count !== 16'(m_miss)) begin n_fail++; $display("FAIL rnd_miss[%0d]: got %0d expected %0d", i, o3_miss_count, m_miss); end
        end
    endtask

    task automatic test_gshare_history();
        int exp_hist;
        int exp_index;
`ifdef BP_GSHARE_HIST_EN
        exp_hist  = 6;
        exp_index = 22;
`else
        exp_hist  = 0;
        exp_index = 16;
`endif
        drive(0, 0, 32'h0, 0, 0, 0, 0, 1);
        drive(1, 0, 32'h0, 1, 0, 1, 1, 1);
        drive(1, 0, 32'h0, 1, 0, 1, 1, 1);
        drive(1, 0, 32'h0, 1, 0, 0, 0, 1);
        n_checks++; if (o2_history !== 6'(exp_hist)) begin n_fail++; $display("FAIL gshare_history: got %b expected %0d", o2_history, exp_hist); end
        drive(1, 1, 32'h40, 0, 0, 0, 0, 1);
        n_checks++; if (o2_pred_index !== 6'(exp_index)) begin n_fail++; $display("FAIL gshare_index: got %0d expected %0d", o2_pred_index, exp_index); end
        n_checks++; if (o2_pred_ctr !== 2'd2) begin n_fail++; $display("FAIL gshare_ctr: got %0d expected 2", o2_pred_ctr); end
    endtask

    task automatic test_miss_saturation();
        for (int i = 0; i < 70000; i++) begin
            bit t;
            t = 1'($urandom);
            drive(1, 0, 32'h0, 1, int'($urandom_range(0, 63)), t, !t, 0);
            n_checks++;
            if (o2_miss_count !== 16'(m_miss)) begin
                n_fail++;
                $display("FAIL miss_run[%0d]: got %0d expected %0d", i, o2_miss_count, m_miss);
            end
        end
        n_checks++; if (o2_miss_count !== 16'hFFFF) begin n_fail++; $display("FAIL miss_sat: got %h expected ffff", o2_miss_count); end
        drive(1, 0, 32'h0, 1, 3, 1, 1, 1);
        n_checks++; if (o2_miss_count !== 16'hFFFF) begin n_fail++; $display("FAIL miss_correct: got %h expected ffff", o2_miss_count); end
        drive(1, 0, 32'h0, 1, 3, 1, 0, 1);
        n_checks++; if (o3_miss_count !== 16'hFFFF) begin n_fail++; $display("FAIL miss_nowrap: got %h expected ffff", o3_miss_count); end
        drive(0, 0, 32'h0, 1, 3, 1, 0, 1);
        n_checks++; if (o2_miss_count !== 16'd0) begin n_fail++; $display("FAIL miss_reset: got %h expected 0", o2_miss_count); end
    endtask

    initial begin
        init_n = 1'b0; pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0; upd_pred_taken = 1'b0;
        model_reset();
        test_reset();
        test_basic_predict();
        test_not_taken_saturation();
        test_taken_saturation();
        test_back_to_back();
        test_random();
        test_gshare_history();
        test_miss_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
